// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to a variable-latency imem and
//   buffers returned {instr, pc} pairs for the IF/ID register. No bypass: request -> response -> buffer head (>=2 cycles).
// Backpressure: PC_EN_IF=0 holds the head and fill continues; requests are issued only while buffer + in-flight < DEPTH.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   PC_EN_IF                     hazard-unit enable; 0 holds the buffer head
//   redirect, redirect_pc        flush and refetch from {redirect_pc[31:2],2'b00}
//   imem_req_valid/ready/addr    request channel to instruction memory
//   imem_resp_valid/data         in-order response channel, one response per accepted request
//   inst_valid_IF, inst_IF,      buffer head presented to IF/ID
//   PC_IF                        (NOP and PC 0 while the buffer is empty)
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_EN_IF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid_IF,
  output logic [31:0] inst_IF,
  output logic [31:0] PC_IF
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CW         = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  // Fetch PC and the queue of PCs for requests still awaiting a response.
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pcq [DEPTH];
  logic [AW-1:0] r_pcq_wr;
  logic [AW-1:0] r_pcq_rd;

  // Fetch buffer of returned instructions.
  logic [31:0]   r_buf_dat [DEPTH];
  logic [31:0]   r_buf_pc  [DEPTH];
  logic [AW-1:0] r_buf_wr;
  logic [AW-1:0] r_buf_rd;
  logic [CW-1:0] r_buf_cnt;

  // Responses owed by memory, and how many of those belong to a flushed path.
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;

  logic [CW:0]   w_credit_used;
  logic          w_hs;
  logic          w_retire;
  logic          w_discard;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [1:0]    w_unused_pc_lsb;

  assign w_unused_pc_lsb = redirect_pc[1:0];

  // Credit counts buffered plus in-flight entries, so a returning response always has a slot.
  assign w_credit_used  = {1'b0, r_buf_cnt} + {1'b0, r_inflight};
  assign imem_req_valid = ~rst & ~redirect & (w_credit_used < CREDIT_MAX);
  assign imem_req_addr  = r_fetch_pc;
  assign w_hs           = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is ignored (and flagged below).
  assign w_retire  = imem_resp_valid & (r_inflight != '0);
  assign w_discard = w_retire & (r_drop != '0);
  assign w_push    = w_retire & ~w_discard & ~redirect;

  assign w_valid = (r_buf_cnt != '0);
  assign w_pop   = w_valid & PC_EN_IF & ~redirect;

  assign inst_valid_IF = w_valid;
  assign inst_IF       = w_valid ? r_buf_dat[r_buf_rd] : NOP;
  assign PC_IF         = w_valid ? r_buf_pc[r_buf_rd]  : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_pcq_wr   <= '0;
      r_pcq_rd   <= '0;
      r_buf_wr   <= '0;
      r_buf_rd   <= '0;
      r_buf_cnt  <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_hs) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      if (w_hs) begin
        r_pcq_wr <= r_pcq_wr + AW'(1);
      end
      if (w_retire) begin
        r_pcq_rd <= r_pcq_rd + AW'(1);
      end

      if (w_hs && !w_retire) begin
        r_inflight <= r_inflight + CW'(1);
      end else if (!w_hs && w_retire) begin
        r_inflight <= r_inflight - CW'(1);
      end

      // Every response still owed after this edge belongs to the old path.
      if (redirect) begin
        r_drop <= r_inflight - CW'(w_retire);
      end else if (w_discard) begin
        r_drop <= r_drop - CW'(1);
      end

      if (redirect) begin
        r_buf_wr  <= '0;
        r_buf_rd  <= '0;
        r_buf_cnt <= '0;
      end else begin
        if (w_push) begin
          r_buf_wr <= r_buf_wr + AW'(1);
        end
        if (w_pop) begin
          r_buf_rd <= r_buf_rd + AW'(1);
        end
        if (w_push && !w_pop) begin
          r_buf_cnt <= r_buf_cnt + CW'(1);
        end else if (!w_push && w_pop) begin
          r_buf_cnt <= r_buf_cnt - CW'(1);
        end
      end
    end
  end

  // Storage arrays need no reset: occupancy is tracked by the pointers and counters above.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_pcq[r_pcq_wr] <= r_fetch_pc;
    end
    if (w_push) begin
      r_buf_dat[r_buf_wr] <= imem_resp_data;
      r_buf_pc[r_buf_wr]  <= r_pcq[r_pcq_rd];
    end
  end

`ifndef SYNTHESIS
  a_resp_without_request: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (r_inflight != '0));
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Testbench for ifetch_stage: randomized memory latency, ready, stall and redirect stimulus,
// checked every cycle against a queue-based model of the fetch stream.
module tb_ifetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PC_EN_IF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid_IF;
  logic [31:0] inst_IF;
  logic [31:0] PC_IF;

  ifetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PC_EN_IF(PC_EN_IF), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid_IF(inst_valid_IF), .inst_IF(inst_IF), .PC_IF(PC_IF)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] dat; } ent_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: memory queue (= requests in flight), visible buffer, drop count.
  mreq_t       mq[$];
  ent_t        mbuf[$];
  int          mdrop;
  logic [31:0] mfetch;
  logic [31:0] stream_pc;
  int          last_due;
  int          lat_min = 1;
  int          lat_max = 1;

  // DUT observations of the most recent cycle.
  bit          g_hs, g_valid, g_req_vld, g_pop;
  logic [31:0] g_addr, g_pc, g_inst;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_clear();
    mq.delete();
    mbuf.delete();
    mdrop     = 0;
    mfetch    = RST_PC;
    stream_pc = RST_PC;
    last_due  = 0;
  endtask

  // Entered and left at posedge+1. redir_mode: 0 none, 1 always, 2 only when response and pop collide.
  task automatic cycle(input bit pc_en, input bit rdy, input int redir_mode, input logic [31:0] rpc,
                       output bit did_redir);
    bit    rv, redir, exp_rv, exp_valid, pop;
    ent_t  hd, n;
    mreq_t e;
    int    due;
    rv    = (mq.size() > 0) && (mq[0].due <= cyc);
    redir = (redir_mode == 1) || (redir_mode == 2 && rv && mbuf.size() > 0 && pc_en);
    PC_EN_IF        = pc_en;
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rv ? memword(mq[0].addr) : $urandom();
    redirect        = redir;
    redirect_pc     = redir ? rpc : $urandom();
    did_redir       = redir;
    @(negedge clk);
    exp_rv    = !redir && ((mbuf.size() + mq.size()) < DEPTH);
    exp_valid = mbuf.size() > 0;
    if (exp_valid) hd = mbuf[0];
    else begin hd.pc = '0; hd.dat = NOP; end
    total++;
    if (imem_req_valid !== exp_rv) begin bad++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv); end
    total++;
    if (imem_req_addr !== mfetch) begin bad++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, mfetch); end
    total++;
    if (inst_valid_IF !== exp_valid) begin bad++; $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_IF, exp_valid); end
    total++;
    if (PC_IF !== hd.pc) begin bad++; $display("FAIL pc_if cyc=%0d got=%h exp=%h", cyc, PC_IF, hd.pc); end
    total++;
    if (inst_IF !== hd.dat) begin bad++; $display("FAIL inst_if cyc=%0d got=%h exp=%h", cyc, inst_IF, hd.dat); end
    pop = exp_valid && pc_en && !redir;
    if (pop) begin
      total++;
      if (PC_IF !== stream_pc) begin bad++; $display("FAIL stream_pc cyc=%0d got=%h exp=%h", cyc, PC_IF, stream_pc); end
      stream_pc = hd.pc + 32'd4;
    end
    g_hs = imem_req_valid && rdy; g_valid = inst_valid_IF; g_req_vld = imem_req_valid; g_pop = pop;
    g_addr = imem_req_addr; g_pc = PC_IF; g_inst = inst_IF;
    // Model update for the coming edge.
    if (pop) hd = mbuf.pop_front();
    if (rv) begin
      e = mq.pop_front();
      if (mdrop > 0) mdrop--;
      else if (!redir) begin n.pc = e.addr; n.dat = memword(e.addr); mbuf.push_back(n); end
    end
    if (redir) begin
      mbuf.delete();
      mdrop     = mq.size();
      mfetch    = {rpc[31:2], 2'b00};
      stream_pc = mfetch;
    end else if (exp_rv && rdy) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      e.addr = mfetch; e.due = due;
      mq.push_back(e);
      mfetch = mfetch + 32'd4;
    end
    @(posedge clk); cyc++; #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL %s_req_valid got=%b exp=0", tag, imem_req_valid); end
    total++; if (inst_valid_IF !== 1'b0) begin bad++; $display("FAIL %s_inst_valid got=%b exp=0", tag, inst_valid_IF); end
    total++; if (inst_IF !== NOP) begin bad++; $display("FAIL %s_inst got=%h exp=%h", tag, inst_IF, NOP); end
    total++; if (PC_IF !== 32'h0) begin bad++; $display("FAIL %s_pc got=%h exp=0", tag, PC_IF); end
  endtask

  task automatic test_reset();
    rst = 1'b0; #1; rst = 1'b1; #1;
    check_reset_outputs("reset");
    @(posedge clk); cyc++; @(posedge clk); cyc++; #1;
    check_reset_outputs("reset_held");
    total++; if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_req_addr, RST_PC); end
    model_clear();
    rst = 1'b0;
  endtask

  task automatic test_startup();
    int c, first_hs, first_v;
    logic [31:0] first_addr, first_vpc;
    bit d;
    int start;
    lat_min = 1; lat_max = 1;
    first_hs = -1; first_v = -1; first_addr = '1; first_vpc = '1;
    start = cyc;
    for (int i = 0; i < 12; i++) begin
      c = cyc;
      cycle(1'b1, 1'b1, 0, 32'h0, d);
      if (g_hs && first_hs < 0) begin first_hs = c; first_addr = g_addr; end
      if (g_valid && first_v < 0) begin first_v = c; first_vpc = g_pc; end
    end
    total++; if (first_hs !== start) begin bad++; $display("FAIL first_req_cycle got=%0d exp=%0d", first_hs, start); end
    total++; if (first_addr !== RST_PC) begin bad++; $display("FAIL first_req_addr got=%h exp=%h", first_addr, RST_PC); end
    total++; if (first_v - first_hs !== 2) begin bad++; $display("FAIL first_valid_latency got=%0d exp=2", first_v - first_hs); end
    total++; if (first_vpc !== RST_PC) begin bad++; $display("FAIL first_valid_pc got=%h exp=%h", first_vpc, RST_PC); end
  endtask

  task automatic test_stall();
    bit d, have;
    logic [31:0] hpc, hinst;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 0, 32'h0, d);
    have = 1'b0; hpc = '0; hinst = '0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 0, 32'h0, d);
      if (have) begin
        total++;
        if (g_pc !== hpc || g_inst !== hinst) begin
          bad++; $display("FAIL stall_hold got=%h/%h exp=%h/%h", g_pc, g_inst, hpc, hinst);
        end
      end else if (g_valid) begin
        have = 1'b1; hpc = g_pc; hinst = g_inst;
      end
    end
    total++; if (g_req_vld !== 1'b0) begin bad++; $display("FAIL stall_credit got=%b exp=0", g_req_vld); end
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 0, 32'h0, d);
  endtask

  task automatic test_redirect();
    bit d, seen;
    logic [31:0] fpc;
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mq.size() != 2; i++) cycle(1'b1, 1'b1, 0, 32'h0, d);
    total++; if (mq.size() != 2) begin bad++; $display("FAIL redir_setup inflight got=%0d exp=2", mq.size()); end
    cycle(1'b1, 1'b1, 1, 32'h0000_0203, d);
    total++; if (g_req_vld !== 1'b0) begin bad++; $display("FAIL redir_req_valid got=%b exp=0", g_req_vld); end
    total++; if (imem_req_addr !== 32'h200) begin bad++; $display("FAIL redir_addr got=%h exp=00000200", imem_req_addr); end
    seen = 1'b0; fpc = '1;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle(1'b1, 1'b1, 0, 32'h0, d);
      if (g_valid) begin seen = 1'b1; fpc = g_pc; end
    end
    total++; if (fpc !== 32'h200) begin bad++; $display("FAIL redir_first_pc got=%h exp=00000200", fpc); end
  endtask

  task automatic test_ready_low();
    bit d;
    logic [31:0] a0;
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 0, 32'h0, d);
    a0 = imem_req_addr;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 0, 32'h0, d);
      total++; if (g_addr !== a0) begin bad++; $display("FAIL rdy_low_addr got=%h exp=%h", g_addr, a0); end
    end
    cycle(1'b1, 1'b1, 0, 32'h0, d);
    total++; if (g_req_vld !== 1'b1) begin bad++; $display("FAIL rdy_rise_valid got=%b exp=1", g_req_vld); end
    cycle(1'b1, 1'b0, 0, 32'h0, d);
    total++; if (g_addr !== a0 + 32'd4) begin bad++; $display("FAIL rdy_single_hs got=%h exp=%h", g_addr, a0 + 32'd4); end
  endtask

  task automatic test_collision();
    bit d;
    lat_min = 1; lat_max = 1;
    d = 1'b0;
    for (int i = 0; i < 30 && !d; i++) cycle(1'b1, 1'b1, 2, 32'h0000_0400, d);
    total++; if (d !== 1'b1) begin bad++; $display("FAIL collide_setup got=%b exp=1", d); end
    total++; if (inst_valid_IF !== 1'b0) begin bad++; $display("FAIL collide_empty got=%b exp=0", inst_valid_IF); end
    total++; if (imem_req_addr !== 32'h400) begin bad++; $display("FAIL collide_addr got=%h exp=00000400", imem_req_addr); end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 0, 32'h0, d);
  endtask

  task automatic test_random();
    bit d;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 39) == 0) ? 1 : 0, $urandom(), d);
    end
  endtask

  task automatic test_async_reset();
    bit d, seen;
    logic [31:0] fpc;
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && mq.size() == 0; i++) cycle(1'b1, 1'b1, 0, 32'h0, d);
    total++; if (mq.size() == 0) begin bad++; $display("FAIL arst_setup inflight got=0 exp>0"); end
    #2;
    rst = 1'b1; imem_resp_valid = 1'b0; redirect = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_clear();
    @(posedge clk); cyc++; @(posedge clk); cyc++; #1;
    rst = 1'b0;
    cycle(1'b1, 1'b1, 0, 32'h0, d);
    total++; if (g_hs !== 1'b1 || g_addr !== RST_PC) begin bad++; $display("FAIL arst_restart got=%b/%h exp=1/%h", g_hs, g_addr, RST_PC); end
    seen = 1'b0; fpc = '1;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1'b1, 1'b1, 0, 32'h0, d);
      if (g_valid) begin seen = 1'b1; fpc = g_pc; end
    end
    total++; if (fpc !== RST_PC) begin bad++; $display("FAIL arst_first_pc got=%h exp=%h", fpc, RST_PC); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_ready_low();
    test_collision();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
